// File: rtl/gpio_int_ctrl_if.sv
// rtl/gpio_int_ctrl_if.sv - control/status bundle between the GPIO register interface and gpio_int_ctrl
interface gpio_int_ctrl_if #(
  parameter int PWIDTH = 8
);
  logic [PWIDTH-1:0] gpio_int_en;
  logic [PWIDTH-1:0] gpio_int_mask;
  logic [PWIDTH-1:0] gpio_int_type;
  logic [PWIDTH-1:0] gpio_int_pol;
  logic [PWIDTH-1:0] gpio_debounce;
  logic [PWIDTH-1:0] gpio_int_clr;
  logic              gpio_int_level_sync;
  logic [PWIDTH-1:0] gpio_ext_data;
  logic [PWIDTH-1:0] gpio_raw_int_status;
  logic [PWIDTH-1:0] gpio_int_status;

  modport master (
    output gpio_int_en, gpio_int_mask, gpio_int_type, gpio_int_pol,
           gpio_debounce, gpio_int_clr, gpio_int_level_sync,
    input  gpio_ext_data, gpio_raw_int_status, gpio_int_status
  );

  modport slave (
    input  gpio_int_en, gpio_int_mask, gpio_int_type, gpio_int_pol,
           gpio_debounce, gpio_int_clr, gpio_int_level_sync,
    output gpio_ext_data, gpio_raw_int_status, gpio_int_status
  );
endinterface

// File: rtl/gpio_int_ctrl.sv
// rtl/gpio_int_ctrl.sv - GPIO pin synchronizer, debounce filter and interrupt status generation
module gpio_int_ctrl #(
  parameter int PWIDTH    = 8,
  parameter int DB_CYCLES = 8,
  parameter int DB_CNT_W  = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [PWIDTH-1:0] gpio_ext_porta,
  gpio_int_ctrl_if.slave    regs,
  output logic [PWIDTH-1:0] gpio_intr,
  output logic              gpio_intr_flag
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [PWIDTH-1:0]               sync1_q;
  logic [PWIDTH-1:0]               sync2_q;
  logic [PWIDTH-1:0]               filt_q;
  logic [PWIDTH-1:0]               filt_d;
  logic [PWIDTH-1:0][DB_CNT_W-1:0] cnt_q;
  logic [PWIDTH-1:0][DB_CNT_W-1:0] cnt_d;
  logic [PWIDTH-1:0]               prev_q;
  logic [PWIDTH-1:0]               sticky_q;
  logic [PWIDTH-1:0]               sticky_d;
  logic [PWIDTH-1:0]               lvl_q;

  logic [PWIDTH-1:0] filtered;
  logic [PWIDTH-1:0] edge_hit;
  logic [PWIDTH-1:0] lvl_hit;
  logic [PWIDTH-1:0] lvl_bit;
  logic [PWIDTH-1:0] raw_status;
  logic [PWIDTH-1:0] int_status;

  // With the filter off, filt_q shadows sync2 so re-enabling it cannot glitch the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < PWIDTH; i++) begin
      if (!regs.gpio_debounce[i]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
      end
    end
  end

  assign filtered = (regs.gpio_debounce & filt_q) | (~regs.gpio_debounce & sync2_q);
  assign edge_hit = (regs.gpio_int_pol & filtered & ~prev_q)
                  | (~regs.gpio_int_pol & ~filtered & prev_q);
  assign lvl_hit  = ~(regs.gpio_int_pol ^ filtered);

  // Set beats clear; disabling or retyping a pin drops its sticky bit on the next edge.
  assign sticky_d = regs.gpio_int_en & regs.gpio_int_type
                  & (edge_hit | (sticky_q & ~regs.gpio_int_clr));

  assign lvl_bit    = regs.gpio_int_level_sync ? lvl_q : lvl_hit;
  assign raw_status = regs.gpio_int_en
                    & ((regs.gpio_int_type & sticky_q) | (~regs.gpio_int_type & lvl_bit));
  assign int_status = raw_status & ~regs.gpio_int_mask;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      lvl_q    <= '0;
    end else begin
      sync1_q  <= gpio_ext_porta;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      prev_q   <= filtered;
      sticky_q <= sticky_d;
      lvl_q    <= lvl_hit;
    end
  end

  assign regs.gpio_ext_data       = filtered;
  assign regs.gpio_raw_int_status = raw_status;
  assign regs.gpio_int_status     = int_status;
  assign gpio_intr                = int_status;
  assign gpio_intr_flag           = |int_status;

endmodule

// File: tb/tb_gpio_int_ctrl.sv
// tb/tb_gpio_int_ctrl.sv - directed self-checking bench for gpio_int_ctrl
module tb_gpio_int_ctrl;

  logic       pclk;
  logic       presetn;
  logic [7:0] gpio_ext_porta;
  logic [7:0] gpio_intr;
  logic       gpio_intr_flag;

  int n_checks;
  int n_errors;

  gpio_int_ctrl_if #(.PWIDTH(8)) regs ();

  gpio_int_ctrl #(
    .PWIDTH   (8),
    .DB_CYCLES(8),
    .DB_CNT_W (8)
  ) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .gpio_ext_porta(gpio_ext_porta),
    .regs          (regs),
    .gpio_intr     (gpio_intr),
    .gpio_intr_flag(gpio_intr_flag)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    presetn                  = 1'b0;
    gpio_ext_porta           = '0;
    regs.gpio_int_en         = '0;
    regs.gpio_int_mask       = '0;
    regs.gpio_int_type       = '0;
    regs.gpio_int_pol        = '0;
    regs.gpio_debounce       = '0;
    regs.gpio_int_clr        = '0;
    regs.gpio_int_level_sync = 1'b0;

    tick();
    tick();
    check("rst_ext_data", 32'(regs.gpio_ext_data), 32'h00);
    check("rst_raw", 32'(regs.gpio_raw_int_status), 32'h00);
    check("rst_status", 32'(regs.gpio_int_status), 32'h00);
    check("rst_flag", 32'(gpio_intr_flag), 32'd0);
    check("rst_intr", 32'(gpio_intr), 32'h00);
    presetn = 1'b1;
    tick();

    // Rising edge on pin0, then write-1-to-clear
    regs.gpio_int_en   = 8'h01;
    regs.gpio_int_type = 8'h01;
    regs.gpio_int_pol  = 8'h01;
    gpio_ext_porta     = 8'h01;
    tick();
    tick();
    check("edge_ext_data_e2", 32'(regs.gpio_ext_data), 32'h01);
    check("edge_raw_e2", 32'(regs.gpio_raw_int_status), 32'h00);
    tick();
    check("edge_raw_e3", 32'(regs.gpio_raw_int_status), 32'h01);
    check("edge_flag", 32'(gpio_intr_flag), 32'd1);
    check("edge_intr", 32'(gpio_intr), 32'h01);
    regs.gpio_int_clr = 8'h01;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("clr_raw", 32'(regs.gpio_raw_int_status), 32'h00);
    check("clr_flag", 32'(gpio_intr_flag), 32'd0);

    // Debounce on pin1: short glitch rejected, long pulse accepted after 2+DB_CYCLES
    regs.gpio_int_en   = 8'h03;
    regs.gpio_int_type = 8'h03;
    regs.gpio_int_pol  = 8'h03;
    regs.gpio_debounce = 8'h02;
    gpio_ext_porta     = 8'h03;
    repeat (5) tick();
    gpio_ext_porta = 8'h01;
    repeat (12) tick();
    check("glitch_ext_data1", 32'(regs.gpio_ext_data[1]), 32'd0);
    check("glitch_raw1", 32'(regs.gpio_raw_int_status[1]), 32'd0);
    gpio_ext_porta = 8'h03;
    repeat (9) tick();
    check("db_ext_data1_e9", 32'(regs.gpio_ext_data[1]), 32'd0);
    tick();
    check("db_ext_data1_e10", 32'(regs.gpio_ext_data[1]), 32'd1);
    tick();
    check("db_raw1_e11", 32'(regs.gpio_raw_int_status[1]), 32'd1);
    repeat (9) tick();
    gpio_ext_porta = 8'h01;
    repeat (12) tick();
    check("db_ext_data1_fall", 32'(regs.gpio_ext_data[1]), 32'd0);
    check("db_raw1_sticky", 32'(regs.gpio_raw_int_status[1]), 32'd1);
    regs.gpio_int_clr = 8'h02;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("db_raw1_clr", 32'(regs.gpio_raw_int_status[1]), 32'd0);
    regs.gpio_debounce = 8'h00;

    // Level active-low on pin2, unsynchronised then synchronised
    regs.gpio_int_en   = 8'h07;
    regs.gpio_int_type = 8'h03;
    regs.gpio_int_pol  = 8'h03;
    gpio_ext_porta     = 8'h05;
    repeat (4) tick();
    check("lvl0_raw2_idle", 32'(regs.gpio_raw_int_status[2]), 32'd0);
    gpio_ext_porta = 8'h01;
    tick();
    check("lvl0_raw2_e1", 32'(regs.gpio_raw_int_status[2]), 32'd0);
    tick();
    check("lvl0_raw2_e2", 32'(regs.gpio_raw_int_status[2]), 32'd1);
    gpio_ext_porta = 8'h05;
    regs.gpio_int_level_sync = 1'b1;
    repeat (4) tick();
    check("lvl1_raw2_idle", 32'(regs.gpio_raw_int_status[2]), 32'd0);
    gpio_ext_porta = 8'h01;
    tick();
    tick();
    check("lvl1_raw2_e2", 32'(regs.gpio_raw_int_status[2]), 32'd0);
    tick();
    check("lvl1_raw2_e3", 32'(regs.gpio_raw_int_status[2]), 32'd1);
    regs.gpio_int_clr = 8'h04;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("lvl_clr_ignored", 32'(regs.gpio_raw_int_status[2]), 32'd1);
    gpio_ext_porta = 8'h05;
    tick();
    tick();
    check("lvl1_release_e2", 32'(regs.gpio_raw_int_status[2]), 32'd1);
    tick();
    check("lvl1_release_e3", 32'(regs.gpio_raw_int_status[2]), 32'd0);

    // Mask hides a pending edge on pin3 until it is lifted
    regs.gpio_int_en   = 8'h0F;
    regs.gpio_int_type = 8'h0B;
    regs.gpio_int_pol  = 8'h0B;
    regs.gpio_int_mask = 8'h08;
    gpio_ext_porta     = 8'h0D;
    repeat (3) tick();
    check("mask_raw3", 32'(regs.gpio_raw_int_status[3]), 32'd1);
    check("mask_status3", 32'(regs.gpio_int_status[3]), 32'd0);
    check("mask_flag", 32'(gpio_intr_flag), 32'd0);
    regs.gpio_int_mask = 8'h00;
    #1;
    check("unmask_status3", 32'(regs.gpio_int_status[3]), 32'd1);
    check("unmask_flag", 32'(gpio_intr_flag), 32'd1);
    check("unmask_intr", 32'(gpio_intr), 32'h08);
    regs.gpio_int_clr = 8'h08;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("mask_clr_raw", 32'(regs.gpio_raw_int_status), 32'h00);

    // Falling edge on pin4 coinciding with a clear: set wins
    regs.gpio_int_en   = 8'h1F;
    regs.gpio_int_type = 8'h1B;
    regs.gpio_int_pol  = 8'h0B;
    gpio_ext_porta     = 8'h1D;
    repeat (4) tick();
    check("fall_raw4_on_rise", 32'(regs.gpio_raw_int_status[4]), 32'd0);
    gpio_ext_porta = 8'h0D;
    tick();
    tick();
    regs.gpio_int_clr = 8'h10;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("setclr_raw4", 32'(regs.gpio_raw_int_status[4]), 32'd1);
    regs.gpio_int_clr = 8'h10;
    tick();
    regs.gpio_int_clr = 8'h00;
    check("setclr_raw4_cleared", 32'(regs.gpio_raw_int_status[4]), 32'd0);

    // Asynchronous reset mid-debounce with a pending edge on pin6
    regs.gpio_int_en   = 8'h7F;
    regs.gpio_int_type = 8'h7B;
    regs.gpio_int_pol  = 8'h6B;
    regs.gpio_debounce = 8'h20;
    gpio_ext_porta     = 8'h6D;
    repeat (5) tick();
    check("pre_rst_raw6", 32'(regs.gpio_raw_int_status[6]), 32'd1);
    check("pre_rst_ext_data5", 32'(regs.gpio_ext_data[5]), 32'd0);
    #2;
    presetn = 1'b0;
    #1;
    check("arst_ext_data", 32'(regs.gpio_ext_data), 32'h00);
    check("arst_raw", 32'(regs.gpio_raw_int_status), 32'h00);
    check("arst_status", 32'(regs.gpio_int_status), 32'h00);
    check("arst_flag", 32'(gpio_intr_flag), 32'd0);
    check("arst_intr", 32'(gpio_intr), 32'h00);
    regs.gpio_debounce = 8'h00;
    tick();
    presetn = 1'b1;
    tick();
    tick();
    check("post_rst_raw5_e2", 32'(regs.gpio_raw_int_status[5]), 32'd0);
    tick();
    check("post_rst_raw5_e3", 32'(regs.gpio_raw_int_status[5]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
